instruction_prefetch_queue: RTL
===============================

# instruction_prefetch_queue

Fetch-side stage that sits directly upstream of the single-cycle core's decode/execute path. It issues read requests to a variable-latency 8-bit instruction memory, buffers returned instruction codes with their PCs in a small FIFO, and presents them to the core over a valid/ready handshake. A taken jump from the core is a redirect: it flushes the queue, discards any in-flight return and restarts fetch at the target.

## Interface
- ADDR_W, 8: PC / memory address width; PC arithmetic wraps modulo 2^ADDR_W.
- DEPTH, 4: queue entries, power of two, ≥2.
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request, registered.
- mem_addr  out  ADDR_W  read address, registered, stable while mem_req=1.
- mem_ack  in  1  memory returns mem_rdata this cycle; sampled only when mem_req=1.
- mem_rdata  in  8  instruction code, valid with mem_ack.
- instr_valid  out  1  queue head valid.
- instr_code  out  8  head instruction code.
- instr_pc  out  ADDR_W  head instruction address.
- instr_ready  in  1  core consumes head on an edge where instr_valid=1.
- redirect  in  1  single-cycle pulse: flush and refetch.
- redirect_target  in  ADDR_W  new fetch PC, valid with redirect.

## Operation
- State: fetch_pc, FIFO (code+pc per entry, head/tail pointers, count 0..DEPTH), FSM {IDLE, WAIT, DROP}.
- Reset values: mem_req=0, mem_addr=0, instr_valid=0, instr_code=0, instr_pc=0, fetch_pc=0, count=0, FSM=IDLE.
- IDLE: no request outstanding. If count < DEPTH and no redirect → mem_req=1, mem_addr=fetch_pc, go WAIT.
- WAIT: request outstanding, mem_req held, mem_addr unchanged until ack.
  - ack, no redirect: push {mem_rdata, mem_addr}; fetch_pc=mem_addr+1. If post-edge count (after push and any pop) < DEPTH → keep mem_req=1 with mem_addr=mem_addr+1, stay WAIT; else mem_req=0, go IDLE.
  - no ack, redirect: go DROP, mem_req stays 1 on the old address.
  - ack and redirect same edge: return discarded, mem_req=0, go IDLE.
- DROP: wait for ack with mem_req held; data discarded; on ack mem_req=0, go IDLE. Further redirects in DROP only update fetch_pc.
- Redirect (any state): count=0, pointers cleared, fetch_pc=redirect_target. Takes priority over push, pop and issue on that edge. A simultaneous pop is void.
- Queue never overflows: a request is issued only when an entry is guaranteed free, counting the outstanding request.
- instr_valid = (count != 0); instr_code/instr_pc come combinationally from head registers. Pop when instr_valid & instr_ready; push and pop on the same edge leave count unchanged.
- Empty: instr_valid=0, instr_ready ignored. Full: mem_req=0 until a pop.

## Timing
- Request latency: mem_req rises at the first edge after Reset deasserts.
- Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
- Data latency: an ack sampled at edge N gives instr_valid=1 with that code after edge N.
- Redirect at edge N: instr_valid=0 after N. With nothing outstanding, mem_req/mem_addr=target after N. With a request outstanding, the target is issued on the edge after the dropped ack.
- Reset assertion mid-transaction clears all outputs immediately (asynchronously). Memory must tolerate an abandoned request.
- PC wrap: 2^ADDR_W−1 is followed by 0, with no gap.

## Test plan
- Reset, zero-wait memory (mem_ack=mem_req, mem_rdata=addr^8'hA5), instr_ready=1 → instr_pc 0,1,2,… one per cycle, instr_code 8'hA5,8'hA4,…
- instr_ready=0 from reset → exactly 4 requests (addr 0–3), then mem_req=0. Head stays pc 0. Raise ready → pcs 0,1,2,3,4 in order with no duplicates or skips.
- Memory with a 3-cycle ack delay → mem_addr stable for the whole request. One instruction per 4 cycles, each arriving one edge after ack.
- Redirect to 8'h40 while addr 5 is outstanding (ack 2 cycles later) → addr 5 data is never presented. Next mem_addr is 8'h40 and next instr_pc is 8'h40.
- Redirect to 8'h10 on the same edge as ack and pop; separately run fetch from 8'hFE → queue empty after redirect and next pc is 8'h10; wrap run gives pcs FE, FF, 00, 01.
- Assert Reset low mid-WAIT with 2 entries queued → mem_req, instr_valid and all outputs 0 immediately. After release, fetch restarts at addr 0.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues reads to a variable-latency instruction
// memory, buffers returned codes with their PCs, and hands them to the core
// over a valid/ready handshake. A redirect flushes the queue, discards any
// in-flight return and restarts fetch at the target.
module instruction_prefetch_queue #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    output logic [7:0]        instr_code,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        WAIT = 2'd1,   // request outstanding, its data will be queued
        DROP = 2'd2    // request outstanding, its data will be discarded
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        code_q [DEPTH];
    logic [7:0]        code_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];

    logic              ack;
    logic              do_push;
    logic              do_pop;
    logic [CNT_W-1:0]  count_post;

    assign ack = req_q & mem_ack;

    // Fetch FSM, queue pointers and occupancy: next-state logic
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        count_post = count_q;

        if (redirect) begin
            // Redirect wins over push, pop and the normal issue this edge.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_target;
            unique case (state_q)
                // Nothing outstanding and the queue is now empty, so the
                // target can be requested straight away.
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = redirect_target;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            do_pop     = (count_q != '0) & instr_ready;
            do_push    = (state_q == WAIT) & ack;
            count_post = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            count_d    = count_post;
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (count_q < CNT_W'(DEPTH)) begin
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        fetch_pc_d = addr_q + ADDR_W'(1);
                        // Only keep requesting while a slot stays reserved.
                        if (count_post < CNT_W'(DEPTH)) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Queue storage: write the returned code and its address at the tail
    always_comb begin
        code_d = code_q;
        pc_d   = pc_q;
        if (do_push) begin
            code_d[tail_q] = mem_rdata;
            pc_d[tail_q]   = addr_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage registers, cleared so the head outputs read 0 in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            code_q <= code_d;
            pc_q   <= pc_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_code  = code_q[head_q];
    assign instr_pc    = pc_q[head_q];

endmodule
